multicycle_control: RTL

//  Multi-cycle successor of the single-cycle MiniMIPS main control: a Moore FSM that

---
 rtl/multicycle_control.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control.sv
// multicycle_control
//   Main control FSM for the multi-cycle MiniMIPS datapath. Each instruction is
//   sequenced through FETCH/DECODE/execute/memory/writeback states, and the FSM
//   drives the shared-datapath enables for the PC, IR, memory, register file and
//   ALU operand muxes. It also handles the memory-ready handshake, traps on
//   illegal opcodes, and counts retired instructions.
// Parameters
//   OPW    opcode width (>=4); any set bit in opcode[OPW-1:4] makes it illegal
//   CNT_W  retired-instruction counter width (the counter wraps)
// Ports
//   clk, rst_n          clock; synchronous active-low reset
//   opcode              IR opcode field, sampled only in DECODE
//   mem_ready           memory done (used in FETCH, MEMRD and MEMWR only)
//   PCWrite .. ALUop    datapath control strobes and mux selects
//   illegal             sticky trap flag, cleared only by reset
//   instr_count         number of instructions retired since reset
module multicycle_control #(
   parameter int OPW   = 4,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [OPW-1:0]   opcode,
   input  logic             mem_ready,
   output logic             PCWrite,
   output logic             PCWriteCond,
   output logic             PCWriteCondNe,
   output logic             IorD,
   output logic             MemRead,
   output logic             MemWrite,
   output logic             IRWrite,
   output logic             MemtoReg,
   output logic             RegDst,
   output logic             RegWrite,
   output logic             ALUSrcA,
   output logic [1:0]       ALUSrcB,
   output logic             PCSource,
   output logic [2:0]       ALUop,
   output logic             illegal,
   output logic [CNT_W-1:0] instr_count
);

   typedef enum logic [3:0] {
      IDLE   = 4'd0,
      FETCH  = 4'd1,
      DECODE = 4'd2,
      MEMADR = 4'd3,
      MEMRD  = 4'd4,
      MEMWB  = 4'd5,
      MEMWR  = 4'd6,
      EXEC   = 4'd7,
      ALUWB  = 4'd8,
      IMMEX  = 4'd9,
      IMMWB  = 4'd10,
      BRANCH = 4'd11,
      TRAP   = 4'd12
   } state_t;

   state_t           state_r;
   state_t           next_state_s;
   logic [3:0]       op_r;
   logic             illegal_r;
   logic [CNT_W-1:0] count_r;
   logic             retire_s;

   // Returns 1 when every opcode bit above the 4-bit base field is clear.
   function automatic logic upper_zero(input logic [OPW-1:0] op);
      logic z;
      z = 1'b1;
      for (int i = 4; i < OPW; i++) begin
         z = z & ~op[i];
      end
      return z;
   endfunction

   // Maps an opcode to the first state after DECODE.
   function automatic state_t decode_target(input logic [OPW-1:0] op);
      state_t t;
      if (!upper_zero(op)) begin
         t = TRAP;
      end else begin
         case (op[3:0])
            4'b0000:                            t = EXEC;
            4'b0001, 4'b0010, 4'b0011,
            4'b0100, 4'b0111:                   t = IMMEX;
            4'b0101, 4'b0110:                   t = BRANCH;
            4'b1000, 4'b1001:                   t = MEMADR;
            default:                            t = TRAP;
         endcase
      end
      return t;
   endfunction

   assign illegal     = illegal_r;
   assign instr_count = count_r;

   // Next-state logic and Moore output decode. Outputs come from the state
   // register, except that IRWrite/PCWrite in FETCH wait for mem_ready.
   always_comb begin
      next_state_s  = state_r;
      retire_s      = 1'b0;
      PCWrite       = 1'b0;
      PCWriteCond   = 1'b0;
      PCWriteCondNe = 1'b0;
      IorD          = 1'b0;
      MemRead       = 1'b0;
      MemWrite      = 1'b0;
      IRWrite       = 1'b0;
      MemtoReg      = 1'b0;
      RegDst        = 1'b0;
      RegWrite      = 1'b0;
      ALUSrcA       = 1'b0;
      ALUSrcB       = 2'b00;
      PCSource      = 1'b0;
      ALUop         = 3'b000;
      case (state_r)
         IDLE: begin
            next_state_s = FETCH;
         end
         FETCH: begin
            MemRead = 1'b1;
            ALUSrcB = 2'b01;
            if (mem_ready) begin
               IRWrite      = 1'b1;
               PCWrite      = 1'b1;
               next_state_s = DECODE;
            end else begin
               next_state_s = FETCH;
            end
         end
         DECODE: begin
            ALUSrcB      = 2'b11;
            next_state_s = decode_target(opcode);
         end
         MEMADR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
            if (op_r == 4'b1000) begin
               next_state_s = MEMRD;
            end else begin
               next_state_s = MEMWR;
            end
         end
         MEMRD: begin
            MemRead = 1'b1;
            IorD    = 1'b1;
            if (mem_ready) begin
               next_state_s = MEMWB;
            end else begin
               next_state_s = MEMRD;
            end
         end
         MEMWB: begin
            RegWrite     = 1'b1;
            MemtoReg     = 1'b1;
            retire_s     = 1'b1;
            next_state_s = FETCH;
         end
         MEMWR: begin
            MemWrite = 1'b1;
            IorD     = 1'b1;
            if (mem_ready) begin
               retire_s     = 1'b1;
               next_state_s = FETCH;
            end else begin
               next_state_s = MEMWR;
            end
         end
         EXEC: begin
            ALUSrcA      = 1'b1;
            ALUop        = 3'b010;
            next_state_s = ALUWB;
         end
         ALUWB: begin
            RegWrite     = 1'b1;
            RegDst       = 1'b1;
            retire_s     = 1'b1;
            next_state_s = FETCH;
         end
         IMMEX: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
            case (op_r)
               4'b0001: ALUop = 3'b000;
               4'b0010: ALUop = 3'b011;
               4'b0011: ALUop = 3'b100;
               4'b0100: ALUop = 3'b101;
               4'b0111: ALUop = 3'b110;
               default: ALUop = 3'b000;
            endcase
            next_state_s = IMMWB;
         end
         IMMWB: begin
            RegWrite     = 1'b1;
            retire_s     = 1'b1;
            next_state_s = FETCH;
         end
         BRANCH: begin
            ALUSrcA  = 1'b1;
            ALUop    = 3'b001;
            PCSource = 1'b1;
            if (op_r == 4'b0101) begin
               PCWriteCond = 1'b1;
            end else begin
               PCWriteCondNe = 1'b1;
            end
            retire_s     = 1'b1;
            next_state_s = FETCH;
         end
         TRAP: begin
            next_state_s = TRAP;
         end
         default: begin
            next_state_s = IDLE;
         end
      endcase
   end

   // State, latched opcode, trap flag and retire counter; reset overrides any
   // state, including one that is stalled on memory.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r   <= IDLE;
         op_r      <= 4'b0000;
         illegal_r <= 1'b0;
         count_r   <= {CNT_W{1'b0}};
      end else begin
         state_r <= next_state_s;
         if (state_r == DECODE) begin
            op_r <= opcode[3:0];
         end else begin
            op_r <= op_r;
         end
         if (next_state_s == TRAP) begin
            illegal_r <= 1'b1;
         end else begin
            illegal_r <= illegal_r;
         end
         if (retire_s) begin
            count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
         end else begin
            count_r <= count_r;
         end
      end
   end

endmodule
